mdu_unit: RTL and testbench
===========================

Name: mdu_unit

Overview:
- Parametrised multi-cycle multiply/divide unit that sits beside the single-cycle ALU in the pipelined MIPS datapath (EX stage).
- Holds the architectural HI/LO registers.
- Executes mult, multu, div and divu over a configurable number of cycles, with a busy flag that the hazard unit uses to stall.
- Services mthi/mtlo writes and mfhi/mflo reads.

Parameters:
- WIDTH, 32, operand/HI/LO width in bits (must be ≥ 2).
- MULT_CYCLES, 5, busy cycles for mult/multu (must be ≥ 1).
- DIV_CYCLES, 10, busy cycles for div/divu (must be ≥ 1).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  instruction-valid strobe for the op on mdu_op.
- mdu_op  input  3  0=mult 1=multu 2=div 3=divu 4=mthi 5=mtlo 6=mfhi 7=mflo.
- SrcA  input  WIDTH  rs operand (multiplicand/dividend/mt data).
- SrcB  input  WIDTH  rt operand (multiplier/divisor).
- busy  output  1  high while a mult/div is in flight.
- HI  output  WIDTH  architectural HI register.
- LO  output  WIDTH  architectural LO register.
- mdu_result  output  WIDTH  mfhi/mflo read data.

Behaviour:
- Reset, sampled on the rising edge of clk when reset=1:
  - HI=0, LO=0, busy=0, cycle counter=0.
  - Any pending result is discarded.
  - reset has priority over every other input, including mid-operation.
- State is a down-counter `cnt`; busy = (cnt != 0). States are IDLE (cnt=0) and RUN (cnt>0).
- Launch from IDLE: start=1 with mdu_op in {0..3} at edge t:
  - SrcA/SrcB are latched.
  - cnt loads MULT_CYCLES (ops 0,1) or DIV_CYCLES (ops 2,3).
  - busy is high for exactly N cycles after edge t.
- In RUN, cnt decrements every edge. On the edge where cnt goes 1→0:
  - HI/LO take the pending result.
  - The new HI/LO are visible in the same cycle busy first reads 0.
- Multiply: the full 2·WIDTH product of the latched operands. HI=upper WIDTH bits, LO=lower WIDTH bits.
  - mult treats both operands as two's-complement.
  - multu treats them as unsigned.
- Divide: LO=quotient, HI=remainder.
  - div is signed: quotient truncates toward zero; remainder takes the sign of the dividend.
  - divu is unsigned.
  - Signed overflow (most-negative ÷ −1): LO=most-negative, HI=0.
  - Divide by zero: the full busy period still elapses, then HI and LO retain their pre-launch values.
- mthi/mtlo: start=1 with op 4/5 while IDLE writes SrcA into HI/LO at that edge. busy stays 0.
- start=1 while busy=1 with any op 0..5: ignored. No relaunch and no HI/LO write. The stall logic must prevent this; the block tolerates it.
- mfhi/mflo: mdu_result is combinational.
  - mdu_result = HI when mdu_op=6, LO when mdu_op=7, else 0.
  - The value is independent of start.
  - While busy, mdu_result shows the pre-operation HI/LO. The pipeline stalls mf* during busy.
- start=1 with op 6/7: no state change.
- Operand inputs may change freely during RUN; only the latched copies are used.
- Back-to-back launch: start may be accepted in the cycle busy first reads 0, and the completed result is already in HI/LO.

Test Plan (WIDTH=32, MULT_CYCLES=5, DIV_CYCLES=10):
- mult −3 × 7 (SrcA=0xFFFFFFFD, SrcB=7) → busy high exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- multu 0xFFFFFFFF × 0xFFFFFFFF → after 5 cycles HI=0xFFFFFFFE, LO=0x00000001.
- div −7 ÷ 2 → busy 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF. Then divu 7 ÷ 2 launched the cycle busy falls → LO=3, HI=1.
- mthi 0x1234, mtlo 0x5678, then div by 0 → busy 10 cycles; HI=0x1234, LO=0x5678 retained. div 0x80000000 ÷ −1 → LO=0x80000000, HI=0.
- Launch mult; at cycle 2 assert start with mtlo 0xAAAA and op mult again → both ignored; the original product lands at cycle 5. mdu_op=7 during busy returns the old LO.
- Launch div; assert reset at cycle 4 → busy=0, HI=LO=0 on the next cycle; no late write occurs.

Source files
------------

// File: rtl/mdu_unit.sv
// Multi-cycle multiply/divide unit holding the architectural HI/LO registers.
// A launched mult/div keeps busy high for a fixed cycle count, then commits HI/LO.
module mdu_unit #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       mdu_op,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    output logic             busy,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO,
    output logic [WIDTH-1:0] mdu_result
);

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5,
        OP_MFHI  = 3'd6,
        OP_MFLO  = 3'd7
    } op_t;

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    logic [CW-1:0]      cnt;
    op_t                op_q;
    op_t                op_in;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;

    logic [2*WIDTH-1:0] ext_a;
    logic [2*WIDTH-1:0] ext_b;
    logic [2*WIDTH-1:0] prod;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   res_hi;
    logic [WIDTH-1:0]   res_lo;
    logic               res_ok;

    assign op_in = op_t'(mdu_op);
    assign busy  = (cnt != '0);

    // One multiplier serves both flavours: sign- or zero-extend to 2*WIDTH, keep the low 2*WIDTH bits.
    // Signed divide runs on magnitudes; the most-negative / -1 case falls out as most-negative, rem 0.
    always_comb begin
        ext_a  = {{WIDTH{(op_q == OP_MULT) & a_q[WIDTH-1]}}, a_q};
        ext_b  = {{WIDTH{(op_q == OP_MULT) & b_q[WIDTH-1]}}, b_q};
        prod   = ext_a * ext_b;
        a_neg  = (op_q == OP_DIV) & a_q[WIDTH-1];
        b_neg  = (op_q == OP_DIV) & b_q[WIDTH-1];
        mag_a  = a_neg ? -a_q : a_q;
        mag_b  = b_neg ? -b_q : b_q;
        quo    = '0;
        rem    = '0;
        if (mag_b != '0) begin
            quo = mag_a / mag_b;
            rem = mag_a % mag_b;
        end
        res_hi = '0;
        res_lo = '0;
        res_ok = 1'b0;
        case (op_q)
            OP_MULT, OP_MULTU: begin
                res_hi = prod[2*WIDTH-1:WIDTH];
                res_lo = prod[WIDTH-1:0];
                res_ok = 1'b1;
            end
            default: begin
                res_lo = (a_neg ^ b_neg) ? -quo : quo;
                res_hi = a_neg ? -rem : rem;
                res_ok = (b_q != '0);
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt  <= '0;
            HI   <= '0;
            LO   <= '0;
            op_q <= OP_MULT;
            a_q  <= '0;
            b_q  <= '0;
        end else if (cnt == '0) begin
            if (start) begin
                case (op_in)
                    OP_MULT, OP_MULTU: begin
                        op_q <= op_in;
                        a_q  <= SrcA;
                        b_q  <= SrcB;
                        cnt  <= CW'(MULT_CYCLES);
                    end
                    OP_DIV, OP_DIVU: begin
                        op_q <= op_in;
                        a_q  <= SrcA;
                        b_q  <= SrcB;
                        cnt  <= CW'(DIV_CYCLES);
                    end
                    OP_MTHI: HI <= SrcA;
                    OP_MTLO: LO <= SrcA;
                    default: ;
                endcase
            end
        end else begin
            cnt <= cnt - CW'(1);
            if (cnt == CW'(1) && res_ok) begin
                HI <= res_hi;
                LO <= res_lo;
            end
        end
    end

    always_comb begin
        case (op_in)
            OP_MFHI: mdu_result = HI;
            OP_MFLO: mdu_result = LO;
            default: mdu_result = '0;
        endcase
    end

endmodule

// File: tb/tb_mdu_unit.sv
// Bench for mdu_unit: arithmetic reference model compared every cycle, plus literal checks.
module tb_mdu_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  mdu_op = 3'd0;
    logic [31:0] SrcA = '0;
    logic [31:0] SrcB = '0;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [31:0] mdu_result;

    int n_cmp = 0;
    int n_bad = 0;
    bit armed = 1'b0;

    mdu_unit #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .start(start), .mdu_op(mdu_op),
        .SrcA(SrcA), .SrcB(SrcB), .busy(busy), .HI(HI), .LO(LO),
        .mdu_result(mdu_result)
    );

    always #5 clk = ~clk;

    // Reference state: architectural HI/LO, remaining busy cycles, result pending at launch.
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
    logic [31:0] p_hi = '0;
    logic [31:0] p_lo = '0;
    bit          p_ok = 1'b0;
    int          m_rem = 0;
    bit          c_ok;
    logic [31:0] c_hi;
    logic [31:0] c_lo;

    function automatic void model_calc(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                       output bit ok, output logic [31:0] h, output logic [31:0] l);
        longint      sp;
        logic [63:0] up;
        int          q;
        int          r;
        ok = 1'b1;
        h  = '0;
        l  = '0;
        case (op)
            3'd0: begin
                sp = longint'($signed(a)) * longint'($signed(b));
                {h, l} = sp;
            end
            3'd1: begin
                up = {32'd0, a} * {32'd0, b};
                {h, l} = up;
            end
            3'd2: begin
                if (b == 32'd0) ok = 1'b0;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    l = 32'h8000_0000;
                    h = 32'd0;
                end else begin
                    q = int'($signed(a)) / int'($signed(b));
                    r = int'($signed(a)) % int'($signed(b));
                    l = 32'(q);
                    h = 32'(r);
                end
            end
            default: begin
                if (b == 32'd0) ok = 1'b0;
                else begin
                    l = a / b;
                    h = a % b;
                end
            end
        endcase
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_hi  <= '0;
            m_lo  <= '0;
            m_rem <= 0;
        end else if (m_rem > 0) begin
            m_rem <= m_rem - 1;
            if (m_rem == 1 && p_ok) begin
                m_hi <= p_hi;
                m_lo <= p_lo;
            end
        end else if (start) begin
            if (mdu_op <= 3'd3) begin
                model_calc(mdu_op, SrcA, SrcB, c_ok, c_hi, c_lo);
                p_ok  <= c_ok;
                p_hi  <= c_hi;
                p_lo  <= c_lo;
                m_rem <= (mdu_op < 3'd2) ? 5 : 10;
            end else if (mdu_op == 3'd4) begin
                m_hi <= SrcA;
            end else if (mdu_op == 3'd5) begin
                m_lo <= SrcA;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (armed) begin
            check("busy", {31'd0, busy}, {31'd0, m_rem != 0});
            check("HI", HI, m_hi);
            check("LO", LO, m_lo);
            check("mdu_result", mdu_result, (mdu_op == 3'd6) ? m_hi : (mdu_op == 3'd7) ? m_lo : 32'd0);
        end
    end

    task automatic drive(input logic s, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        start  = s;
        mdu_op = op;
        SrcA   = a;
        SrcB   = b;
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input int n);
        int k = 0;
        drive(1'b1, op, a, b);
        while (busy === 1'b1 && k < 40) begin
            drive(1'b0, 3'd6, $urandom(), $urandom());
            k++;
        end
        check("busy_len", 32'(k), 32'(n));
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'($urandom_range(0, 20));
            default: return 32'($urandom());
        endcase
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int k;
        drive(1'b0, 3'd0, '0, '0);
        armed = 1'b1;
        drive(1'b0, 3'd0, '0, '0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_HI", HI, 32'd0);
        check("reset_LO", LO, 32'd0);
        reset = 1'b0;

        run_op(3'd0, 32'hFFFF_FFFD, 32'd7, 5);
        check("mult_HI", HI, 32'hFFFF_FFFF);
        check("mult_LO", LO, 32'hFFFF_FFEB);

        run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5);
        check("multu_HI", HI, 32'hFFFF_FFFE);
        check("multu_LO", LO, 32'h0000_0001);

        run_op(3'd2, 32'hFFFF_FFF9, 32'd2, 10);
        check("div_LO", LO, 32'hFFFF_FFFD);
        check("div_HI", HI, 32'hFFFF_FFFF);
        run_op(3'd3, 32'd7, 32'd2, 10);
        check("divu_LO", LO, 32'd3);
        check("divu_HI", HI, 32'd1);

        drive(1'b1, 3'd4, 32'h1234, 32'd0);
        drive(1'b1, 3'd5, 32'h5678, 32'd0);
        check("mt_busy", {31'd0, busy}, 32'd0);
        run_op(3'd2, 32'd55, 32'd0, 10);
        check("div0_HI", HI, 32'h1234);
        check("div0_LO", LO, 32'h5678);
        run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 10);
        check("ovf_LO", LO, 32'h8000_0000);
        check("ovf_HI", HI, 32'd0);

        drive(1'b1, 3'd0, 32'd3, 32'd4);
        drive(1'b0, 3'd0, 32'd9, 32'd9);
        drive(1'b1, 3'd5, 32'hAAAA, 32'd0);
        drive(1'b1, 3'd0, 32'd100, 32'd100);
        drive(1'b0, 3'd7, 32'd0, 32'd0);
        check("mflo_busy", mdu_result, 32'h8000_0000);
        check("busy_mid", {31'd0, busy}, 32'd1);
        k = 0;
        while (busy === 1'b1 && k < 40) begin
            drive(1'b0, 3'd7, $urandom(), $urandom());
            k++;
        end
        check("ignore_len", 32'(k + 4), 32'd5);
        check("ignore_LO", LO, 32'd12);
        check("ignore_HI", HI, 32'd0);

        drive(1'b1, 3'd2, 32'd100, 32'd7);
        for (int i = 0; i < 3; i++) drive(1'b0, 3'd6, '0, '0);
        reset = 1'b1;
        drive(1'b0, 3'd6, '0, '0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_HI", HI, 32'd0);
        check("rst_LO", LO, 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 12; i++) drive(1'b0, 3'd7, '0, '0);
        check("rst_late_HI", HI, 32'd0);
        check("rst_late_LO", LO, 32'd0);

        for (int i = 0; i < 1500; i++) begin
            reset = ($urandom_range(0, 149) == 0);
            drive($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), pick(), pick());
        end
        reset = 1'b0;
        for (int i = 0; i < 12; i++) drive(1'b0, 3'd6, '0, '0);

        armed = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
